spike_packet_receiver: RTL and testbench
========================================

Name: spike_packet_receiver

Overview:
- Receive side of the 30-bit spike packet interface emitted by a neuron grid (packet_out / spike_out_valid / local_buffers_full).
- Buffers incoming packets in a small FIFO, decodes each one, and sets the addressed axon bit in a tick-indexed scheduler ring of 256-bit bitmaps.
- Presents the current tick's bitmap as axon_spikes to the destination core's neuron grid.
- Back-pressures the sender with local_buffers_full.

Parameters:
- FIFO_DEPTH, 8, packet FIFO entries (power of 2, ≥2)
- TICK_SLOTS, 16, scheduler ring slots (power of 2, ≤16; 4-bit offset field)
- NUM_AXONS, 256, bitmap width (fixed; axon field is 8 bits)

Ports:
- clk  input  1  system clock
- reset_n  input  1  synchronous active-low reset, sampled on rising clk
- tick  input  1  one-cycle pulse: advance to the next tick slot
- packet_in  input  30  spike packet: [29:21] dx, [20:12] dy, [11:8] delivery offset, [7:0] axon index
- packet_in_valid  input  1  packet_in valid this cycle
- scheduler_clr  input  1  one-cycle pulse from the grid controller: clear the current slot after consumption
- local_buffers_full  output  1  FIFO full; sender must hold packets
- axon_spikes  output  256  bitmap of the current slot
- busy  output  1  FIFO non-empty
- error  output  1  one-cycle pulse on a dropped packet

Behaviour:
- Reset (reset_n low at a clk edge):
  - FIFO empty; rd_ptr=0; all slot bitmaps 0.
  - Outputs: local_buffers_full=0, busy=0, error=0, axon_spikes=0.
  - Reset mid-operation discards all queued packets and scheduled spikes.
- Push:
  - packet_in_valid && !local_buffers_full → packet written to FIFO on that edge.
  - packet_in_valid while full → packet dropped, error=1 next cycle.
  - Full is evaluated before the same-cycle pop, so a push is never accepted in a full cycle even if a pop frees space.
- local_buffers_full = (count==FIFO_DEPTH), registered from count.
- busy = (count!=0).
- FSM, states RUN and ADVANCE:
  - RUN: if tick → ADVANCE (no pop this cycle). Otherwise, if the FIFO is non-empty, pop the head and decode it.
  - ADVANCE (1 cycle): rd_ptr ← (rd_ptr+1) mod TICK_SLOTS; no pop; return to RUN.
  - tick arriving while in ADVANCE is honoured: stay in ADVANCE for another increment.
- Decode of the popped packet:
  - dx!=0 or dy!=0 → not local; drop, error pulse.
  - offset==0 or offset ≥ TICK_SLOTS → drop, error pulse.
  - Otherwise set bit [axon] of slot[(rd_ptr+offset) mod TICK_SLOTS]; the slot index wraps around.
  - Duplicate packets are idempotent (OR).
- Latency: packet accepted at edge N is popped at N+1 at the earliest; its bitmap bit is visible in the slot register after edge N+2. It appears on axon_spikes once rd_ptr reaches its slot.
- axon_spikes: combinational read of slot[rd_ptr]; it changes the cycle after ADVANCE.
- scheduler_clr clears slot[rd_ptr] on that edge.
  - A pop can never target slot[rd_ptr] (offset≥1), so clear and set never collide.
  - scheduler_clr coinciding with tick: the clear applies to the old rd_ptr slot, then the advance occurs.
- Back-to-back packets: sustained rate of 1 packet/cycle outside ADVANCE cycles.
- error pulses from push-overflow and decode-drop in the same cycle collapse into a single pulse.

Decomposition:
- Package snn_packet_pkg:
  - Field LSB/MSB constants for dx, dy, offset, axon.
  - PACKET_W=30, NUM_AXONS=256.
  - FSM state enum.
- Sub-module packet_fifo: synchronous FIFO with push/pop, count, full and empty, same clk/reset_n.
- Top level holds the FSM, decode and the slot bitmap ring.

Test Plan:
- Reset, then a single packet dx=0, dy=0, offset=1, axon=5 → bit 5 of slot1 set; after one tick, axon_spikes = 1<<5; scheduler_clr → axon_spikes = 0.
- rd_ptr=15, packet with offset=2, axon=255 → slot 1 set (wrap); two ticks later axon_spikes[255]=1, all other bits 0.
- Nine consecutive valid packets with no pops possible (tick held asserted) → local_buffers_full=1 after 8, 9th dropped with an error pulse; FIFO drains after tick is released.
- Packet with dx=1, and packet with offset=0 → each produces one error pulse; no bitmap bit changes.
- tick and scheduler_clr in the same cycle, with a packet queued → old slot cleared, rd_ptr+1, packet popped the following cycle into the correct slot.
- Assert reset_n low mid-burst with a non-empty FIFO → next cycle busy=0, full=0, axon_spikes=0; a packet pushed afterwards decodes normally.

Source files
------------

// File: rtl/snn_packet_pkg.sv
// Shared field positions, sizes and FSM state type for the spike packet receive path.
package snn_packet_pkg;

    localparam int PACKET_W  = 30;
    localparam int NUM_AXONS = 256;

    localparam int DX_MSB   = 29;
    localparam int DX_LSB   = 21;
    localparam int DY_MSB   = 20;
    localparam int DY_LSB   = 12;
    localparam int OFF_MSB  = 11;
    localparam int OFF_LSB  = 8;
    localparam int AXON_MSB = 7;
    localparam int AXON_LSB = 0;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_ADVANCE = 1'b1
    } rx_state_e;

endpackage

// File: rtl/packet_fifo.sv
// Synchronous packet FIFO; pushes while full and pops while empty are ignored.
module packet_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 30
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/spike_packet_receiver.sv
// Receives spike packets, queues them, and schedules axon bits into a tick-indexed bitmap ring.
//
// state      | meaning
// ST_RUN     | pop one queued packet per cycle unless tick is asserted
// ST_ADVANCE | step rd_ptr to the next slot; stays here while tick keeps arriving
module spike_packet_receiver
    import snn_packet_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int TICK_SLOTS = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 tick,
    input  logic [PACKET_W-1:0]  packet_in,
    input  logic                 packet_in_valid,
    input  logic                 scheduler_clr,
    output logic                 local_buffers_full,
    output logic [NUM_AXONS-1:0] axon_spikes,
    output logic                 busy,
    output logic                 error
);

    localparam logic [3:0] SLOT_MASK = 4'(TICK_SLOTS - 1);

    logic [PACKET_W-1:0]        fifo_rdata;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       pop;
    logic                       overflow;

    rx_state_e                  state_q;
    logic [3:0]                 rd_ptr_q;
    logic [PACKET_W-1:0]        pkt_q;
    logic                       pkt_vld_q;
    logic                       error_q;
    logic [NUM_AXONS-1:0]       slot_q [TICK_SLOTS];

    logic [8:0]                 pkt_dx;
    logic [8:0]                 pkt_dy;
    logic [3:0]                 pkt_off;
    logic [7:0]                 pkt_axon;
    logic                       pkt_ok;
    logic                       set_en;
    logic                       drop;
    logic [3:0]                 tgt_slot;

    packet_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PACKET_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (packet_in_valid),
        .pop_i   (pop),
        .wdata_i (packet_in),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign local_buffers_full = fifo_full;
    assign busy               = (fifo_count != '0);
    assign error              = error_q;
    assign axon_spikes        = slot_q[rd_ptr_q];

    assign pop      = (state_q == ST_RUN) && !tick && !fifo_empty;
    assign overflow = packet_in_valid && fifo_full;

    // Popped packet sits one cycle in pkt_q and is decoded against the rd_ptr of that cycle.
    assign pkt_dx   = pkt_q[DX_MSB:DX_LSB];
    assign pkt_dy   = pkt_q[DY_MSB:DY_LSB];
    assign pkt_off  = pkt_q[OFF_MSB:OFF_LSB];
    assign pkt_axon = pkt_q[AXON_MSB:AXON_LSB];
    assign pkt_ok   = (pkt_dx == '0) && (pkt_dy == '0) && (pkt_off != '0)
                      && ({1'b0, pkt_off} < 5'(TICK_SLOTS));
    assign set_en   = pkt_vld_q && pkt_ok;
    assign drop     = pkt_vld_q && !pkt_ok;
    assign tgt_slot = (rd_ptr_q + pkt_off) & SLOT_MASK;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_RUN;
            rd_ptr_q  <= '0;
            pkt_q     <= '0;
            pkt_vld_q <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            error_q   <= overflow || drop;
            pkt_vld_q <= pop;
            if (pop) begin
                pkt_q <= fifo_rdata;
            end
            case (state_q)
                ST_RUN: begin
                    if (tick) begin
                        state_q <= ST_ADVANCE;
                    end
                end
                ST_ADVANCE: begin
                    rd_ptr_q <= (rd_ptr_q + 4'd1) & SLOT_MASK;
                    if (!tick) begin
                        state_q <= ST_RUN;
                    end
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

    // Offset is at least 1, so a set never lands on the slot being cleared.
    always_ff @(posedge clk) begin
        for (int i = 0; i < TICK_SLOTS; i++) begin
            if (!reset_n) begin
                slot_q[i] <= '0;
            end else if (scheduler_clr && (rd_ptr_q == 4'(i))) begin
                slot_q[i] <= '0;
            end else if (set_en && (tgt_slot == 4'(i))) begin
                slot_q[i][pkt_axon] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spike_packet_receiver.sv
// Directed bench for spike_packet_receiver with hand-computed expected bitmaps and flags.
module tb_spike_packet_receiver;

    logic         clk;
    logic         reset_n;
    logic         tick;
    logic [29:0]  packet_in;
    logic         packet_in_valid;
    logic         scheduler_clr;
    logic         local_buffers_full;
    logic [255:0] axon_spikes;
    logic         busy;
    logic         error;

    int total = 0;
    int bad   = 0;

    spike_packet_receiver dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .tick               (tick),
        .packet_in          (packet_in),
        .packet_in_valid    (packet_in_valid),
        .scheduler_clr      (scheduler_clr),
        .local_buffers_full (local_buffers_full),
        .axon_spikes        (axon_spikes),
        .busy               (busy),
        .error              (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [29:0] pk(input int dx, input int dy, input int off, input int ax);
        return {9'(dx), 9'(dy), 4'(off), 8'(ax)};
    endfunction

    function automatic logic [255:0] bit_at(input int idx);
        logic [255:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    task automatic send(input logic [29:0] p);
        packet_in       = p;
        packet_in_valid = 1'b1;
        cyc(1);
        packet_in_valid = 1'b0;
    endtask

    // Holding tick for k cycles then releasing advances rd_ptr by exactly k.
    task automatic advance(input int k);
        tick = 1'b1;
        cyc(k);
        tick = 1'b0;
        cyc(1);
    endtask

    task automatic clr_slot();
        scheduler_clr = 1'b1;
        cyc(1);
        scheduler_clr = 1'b0;
    endtask

    logic [255:0] exp_map;

    initial begin
        reset_n         = 1'b0;
        tick            = 1'b0;
        packet_in       = '0;
        packet_in_valid = 1'b0;
        scheduler_clr   = 1'b0;
        cyc(3);
        chk("rst_full", 256'(local_buffers_full), 256'(0));
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_error", 256'(error), 256'(0));
        chk("rst_axon", axon_spikes, '0);
        reset_n = 1'b1;
        cyc(1);

        // single local packet, offset 1, axon 5 -> slot 1
        send(pk(0, 0, 1, 5));
        chk("t1_busy_after_push", 256'(busy), 256'(1));
        cyc(1);
        chk("t1_busy_after_pop", 256'(busy), 256'(0));
        cyc(1);
        chk("t1_slot0_empty", axon_spikes, '0);
        chk("t1_no_error", 256'(error), 256'(0));
        advance(1);
        chk("t1_slot1", axon_spikes, bit_at(5));
        clr_slot();
        chk("t1_cleared", axon_spikes, '0);

        // rd_ptr 1 -> 15, offset 2 wraps to slot 1
        advance(14);
        chk("t2_slot15_empty", axon_spikes, '0);
        send(pk(0, 0, 2, 255));
        cyc(2);
        advance(1);
        chk("t2_slot0", axon_spikes, '0);
        advance(1);
        chk("t2_slot1_wrap", axon_spikes, bit_at(255));
        clr_slot();

        // nine pushes with tick held: eight queued, ninth dropped
        tick = 1'b1;
        for (int i = 0; i < 9; i++) begin
            packet_in       = pk(0, 0, 3, 10 + i);
            packet_in_valid = 1'b1;
            cyc(1);
            if (i == 6) chk("t3_not_full_7", 256'(local_buffers_full), 256'(0));
            if (i == 7) begin
                chk("t3_full_8", 256'(local_buffers_full), 256'(1));
                chk("t3_no_err_8", 256'(error), 256'(0));
            end
            if (i == 8) chk("t3_err_9", 256'(error), 256'(1));
        end
        packet_in_valid = 1'b0;
        tick = 1'b0;
        cyc(1);
        chk("t3_err_single", 256'(error), 256'(0));
        cyc(9);
        chk("t3_drained_busy", 256'(busy), 256'(0));
        chk("t3_drained_full", 256'(local_buffers_full), 256'(0));
        // rd_ptr was 1, advanced 9 -> 10; offset 3 -> slot 13
        advance(3);
        exp_map = '0;
        for (int a = 10; a < 18; a++) exp_map[a] = 1'b1;
        chk("t3_slot13", axon_spikes, exp_map);
        clr_slot();
        chk("t3_cleared", axon_spikes, '0);

        // non-local and zero-offset packets each give one error pulse
        send(pk(1, 0, 1, 20));
        cyc(1);
        chk("t4_dx_err_early", 256'(error), 256'(0));
        cyc(1);
        chk("t4_dx_err", 256'(error), 256'(1));
        cyc(1);
        chk("t4_dx_err_end", 256'(error), 256'(0));
        send(pk(0, 0, 0, 21));
        cyc(2);
        chk("t4_off0_err", 256'(error), 256'(1));
        cyc(1);
        chk("t4_off0_err_end", 256'(error), 256'(0));
        chk("t4_slot13_clean", axon_spikes, '0);
        advance(1);
        chk("t4_slot14_clean", axon_spikes, '0);

        // tick + clear together with a packet queued
        send(pk(0, 0, 1, 40));
        cyc(2);
        advance(1);
        chk("t5_slot15", axon_spikes, bit_at(40));
        send(pk(0, 0, 2, 50));
        tick          = 1'b1;
        scheduler_clr = 1'b1;
        cyc(1);
        tick          = 1'b0;
        scheduler_clr = 1'b0;
        chk("t5_old_slot_cleared", axon_spikes, '0);
        chk("t5_still_queued", 256'(busy), 256'(1));
        cyc(1);
        chk("t5_queued_in_adv", 256'(busy), 256'(1));
        cyc(2);
        chk("t5_popped", 256'(busy), 256'(0));
        advance(2);
        chk("t5_slot2", axon_spikes, bit_at(50));

        // reset mid-burst
        for (int i = 0; i < 3; i++) begin
            packet_in       = pk(0, 0, 3, 60 + i);
            packet_in_valid = 1'b1;
            cyc(1);
        end
        packet_in_valid = 1'b0;
        chk("t6_busy_pre", 256'(busy), 256'(1));
        chk("t6_axon_pre", axon_spikes, bit_at(50));
        reset_n = 1'b0;
        cyc(1);
        reset_n = 1'b1;
        chk("t6_busy", 256'(busy), 256'(0));
        chk("t6_full", 256'(local_buffers_full), 256'(0));
        chk("t6_axon", axon_spikes, '0);
        chk("t6_error", 256'(error), 256'(0));
        send(pk(0, 0, 1, 77));
        cyc(2);
        chk("t6_post_err", 256'(error), 256'(0));
        advance(1);
        chk("t6_post_slot1", axon_spikes, bit_at(77));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
